// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: RAM_CTRL field positions,
// access-size encodings and the two FSM state codes.
package mem_access_stage_pkg;

   // RAM_CTRL bit positions
   localparam int CTRL_EN    = 3;
   localparam int CTRL_WR    = 2;
   localparam int CTRL_SZ_HI = 1;
   localparam int CTRL_SZ_LO = 0;

   // Access sizes carried in RAM_CTRL[1:0]
   localparam logic [1:0] SZ_B   = 2'b00;
   localparam logic [1:0] SZ_H   = 2'b01;
   localparam logic [1:0] SZ_W   = 2'b10;
   localparam logic [1:0] SZ_RSV = 2'b11;

   // FSM states (IDLE / BUSY)
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // True when an access of the given size is not naturally aligned
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      return ((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_stage_data_ram.sv
// Private data RAM of the memory-access stage: byte array with four byte-lane
// write enables and an asynchronous big-endian 32-bit read at a word base.
module data_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic [ADDR_W-3:0] i_word_addr,
   input  logic [3:0]        i_be,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata
);

   // NOTE: the array has no reset; its contents are undefined until written,
   // which keeps it mappable onto plain RAM cells.
   logic [7:0] r_mem [2**ADDR_W];

   // Asynchronous big-endian read: lowest byte address lands in bits [31:24]
   always_comb begin
      o_rdata = {r_mem[{i_word_addr, 2'b00}], r_mem[{i_word_addr, 2'b01}],
                 r_mem[{i_word_addr, 2'b10}], r_mem[{i_word_addr, 2'b11}]};
   end

   // Synchronous byte-lane writes; lane enable [3] covers the lowest address
   // NOTE: non-blocking assignments for every clocked state update so all
   // registers sample pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_be[3]) r_mem[{i_word_addr, 2'b00}] <= i_wdata[31:24];
      if (i_be[2]) r_mem[{i_word_addr, 2'b01}] <= i_wdata[23:16];
      if (i_be[1]) r_mem[{i_word_addr, 2'b10}] <= i_wdata[15:8];
      if (i_be[0]) r_mem[{i_word_addr, 2'b11}] <= i_wdata[7:0];
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: byte/halfword/word big-endian loads and stores on a
// private data RAM, configurable wait states with upstream stall, and the
// MEM/WB pipeline register plus MEM forwarding value.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int WAIT   = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] EX_OUT,
   input  logic [31:0] EX_DI,
   input  logic [4:0]  EX_RD,
   input  logic        EX_L,
   input  logic        EX_RF_LE,
   input  logic [3:0]  RAM_CTRL,
   output logic        MEM_STALL,
   output logic [31:0] PD_MEM,
   output logic [4:0]  MEM_RD,
   output logic        MEM_RF_LE,
   output logic        MISALIGN,
   output logic [31:0] WB_PD,
   output logic [4:0]  WB_RD,
   output logic        WB_RF_LE
);

   localparam logic [2:0] WAIT_C = 3'(WAIT);

   logic [0:0]        r_state;
   logic [2:0]        r_cnt;
   logic [31:0]       r_wb_pd;
   logic [4:0]        r_wb_rd;
   logic              r_wb_rf_le;

   logic [ADDR_W-1:0] w_addr;
   logic [1:0]        w_off;
   logic [1:0]        w_sz;
   logic              w_wr;
   logic              w_acc;
   logic              w_mis;
   logic              w_commit;
   logic              w_we;
   logic              w_rf_le;
   logic [31:0]       w_rdata;
   logic [31:0]       w_ld;
   logic [31:0]       w_res;
   logic [31:0]       w_wdata;
   logic [3:0]        w_be;
   logic [3:0]        w_be_q;

   assign w_addr = EX_OUT[ADDR_W-1:0];
   assign w_off  = w_addr[1:0];
   assign w_sz   = RAM_CTRL[CTRL_SZ_HI:CTRL_SZ_LO];
   assign w_wr   = RAM_CTRL[CTRL_WR];
   assign w_acc  = RAM_CTRL[CTRL_EN] && (w_sz != SZ_RSV);
   assign w_mis  = w_acc && is_misaligned(w_sz, w_off);

   // Commit when idle with nothing to wait for, or when the last wait state ends
   always_comb begin
      if (r_state == ST_IDLE) w_commit = !w_acc || w_mis || (WAIT_C == 3'd0);
      else                    w_commit = (r_cnt == WAIT_C);
   end

   // Load formatting: pick the addressed byte/halfword and zero-extend
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_ld = '0;
      case (w_sz)
         SZ_B:    w_ld = {24'h0, 8'(w_rdata >> {~w_off, 3'b000})};
         SZ_H:    w_ld = {16'h0, 16'(w_rdata >> {~w_off[1], 4'b0000})};
         SZ_W:    w_ld = w_rdata;
         default: w_ld = '0;
      endcase
   end

   // Store lane steering: replicate the low bits of EX_DI onto the selected lanes
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = EX_DI;
      case (w_sz)
         SZ_B: begin
            w_be    = 4'b1000 >> w_off;
            w_wdata = {4{EX_DI[7:0]}};
         end
         SZ_H: begin
            w_be    = w_off[1] ? 4'b0011 : 4'b1100;
            w_wdata = {2{EX_DI[15:0]}};
         end
         SZ_W: begin
            w_be    = 4'b1111;
            w_wdata = EX_DI;
         end
         default: w_be = 4'b0000;
      endcase
   end

   // A store lands only in its commit cycle, never when misaligned or under reset
   assign w_we    = w_commit && w_acc && w_wr && !w_mis && !RST;
   assign w_be_q  = w_we ? w_be : 4'b0000;

   assign w_res     = w_mis ? 32'h0 : (EX_L ? w_ld : EX_OUT);
   assign w_rf_le   = EX_RF_LE && !(w_mis && !w_wr);

   assign MEM_STALL = !w_commit;
   assign MISALIGN  = w_mis;
   assign PD_MEM    = w_res;
   assign MEM_RD    = EX_RD;
   assign MEM_RF_LE = w_rf_le;
   assign WB_PD     = r_wb_pd;
   assign WB_RD     = r_wb_rd;
   assign WB_RF_LE  = r_wb_rf_le;

   data_ram #(.ADDR_W(ADDR_W)) u_ram (
      .i_clk       (CLK),
      .i_word_addr (w_addr[ADDR_W-1:2]),
      .i_be        (w_be_q),
      .i_wdata     (w_wdata),
      .o_rdata     (w_rdata)
   );

   // Wait-state FSM: IDLE launches an aligned access, BUSY counts up to WAIT
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_acc && !w_mis && (WAIT_C != 3'd0)) begin
                  r_state <= ST_BUSY;
                  r_cnt   <= 3'd1;
               end
            end
            ST_BUSY: begin
               if (r_cnt == WAIT_C) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= 3'd0;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= 3'd0;
            end
         endcase
      end
   end

   // MEM/WB register: load the result on commit, insert a bubble while stalled
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wb_pd    <= '0;
         r_wb_rd    <= '0;
         r_wb_rf_le <= 1'b0;
      end else if (w_commit) begin
         r_wb_pd    <= w_res;
         r_wb_rd    <= EX_RD;
         r_wb_rf_le <= w_rf_le;
      end else begin
         r_wb_rf_le <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: three instances (WAIT = 0, 2, 3)
// against a transaction-level reference model, plus directed literal checks.
module tb_mem_access_stage;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst       [N];
   logic [31:0] ex_out    [N];
   logic [31:0] ex_di     [N];
   logic [4:0]  ex_rd     [N];
   logic        ex_l      [N];
   logic        ex_rf_le  [N];
   logic [3:0]  ram_ctrl  [N];
   logic        mem_stall [N];
   logic [31:0] pd_mem    [N];
   logic [4:0]  mem_rd    [N];
   logic        mem_rf_le [N];
   logic        misalign  [N];
   logic [31:0] wb_pd     [N];
   logic [4:0]  wb_rd     [N];
   logic        wb_rf_le  [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_access_stage #(.ADDR_W(8), .WAIT((g == 0) ? 0 : g + 1)) u_dut (
         .CLK       (clk),
         .RST       (rst[g]),
         .EX_OUT    (ex_out[g]),
         .EX_DI     (ex_di[g]),
         .EX_RD     (ex_rd[g]),
         .EX_L      (ex_l[g]),
         .EX_RF_LE  (ex_rf_le[g]),
         .RAM_CTRL  (ram_ctrl[g]),
         .MEM_STALL (mem_stall[g]),
         .PD_MEM    (pd_mem[g]),
         .MEM_RD    (mem_rd[g]),
         .MEM_RF_LE (mem_rf_le[g]),
         .MISALIGN  (misalign[g]),
         .WB_PD     (wb_pd[g]),
         .WB_RD     (wb_rd[g]),
         .WB_RF_LE  (wb_rf_le[g])
      );
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : k + 1;
   endfunction

   // Reference model state: byte memory, WB register image, remaining stall
   // cycles of the instruction in flight (-1 = next cycle starts a new one).
   logic [7:0]  mm       [N][256];
   logic [31:0] m_wb_pd  [N];
   logic [4:0]  m_wb_rd  [N];
   logic        m_wb_le  [N];
   int          left     [N];
   int          n_commit [N];

   // Compare process: evaluate the model mid-cycle, check outputs, advance model
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         logic        acc, wr, mis, le;
         logic [1:0]  sz;
         logic [7:0]  a;
         logic [31:0] ld, res;
         acc = ram_ctrl[k][3] && (ram_ctrl[k][1:0] != 2'b11);
         wr  = ram_ctrl[k][2];
         sz  = ram_ctrl[k][1:0];
         a   = ex_out[k][7:0];
         mis = acc && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00));
         case (sz)
            2'd0:    ld = {24'h0, mm[k][a]};
            2'd1:    ld = {16'h0, mm[k][a], mm[k][a + 8'd1]};
            2'd2:    ld = {mm[k][a], mm[k][a + 8'd1], mm[k][a + 8'd2], mm[k][a + 8'd3]};
            default: ld = 32'h0;
         endcase
         res = mis ? 32'h0 : (ex_l[k] ? ld : ex_out[k]);
         le  = ex_rf_le[k] && !(mis && !wr);
         if (left[k] < 0) left[k] = (acc && !mis) ? wait_of(k) : 0;

         check($sformatf("i%0d MEM_STALL", k), {31'h0, mem_stall[k]}, {31'h0, left[k] > 0});
         check($sformatf("i%0d MISALIGN", k), {31'h0, misalign[k]}, {31'h0, mis});
         check($sformatf("i%0d MEM_RD", k), {27'h0, mem_rd[k]}, {27'h0, ex_rd[k]});
         check($sformatf("i%0d MEM_RF_LE", k), {31'h0, mem_rf_le[k]}, {31'h0, le});
         if (left[k] == 0) check($sformatf("i%0d PD_MEM", k), pd_mem[k], res);
         check($sformatf("i%0d WB_PD", k), wb_pd[k], m_wb_pd[k]);
         check($sformatf("i%0d WB_RD", k), {27'h0, wb_rd[k]}, {27'h0, m_wb_rd[k]});
         check($sformatf("i%0d WB_RF_LE", k), {31'h0, wb_rf_le[k]}, {31'h0, m_wb_le[k]});

         if (rst[k]) begin
            m_wb_pd[k] = '0;
            m_wb_rd[k] = '0;
            m_wb_le[k] = 1'b0;
            left[k]    = -1;
         end else if (left[k] == 0) begin
            if (acc && wr && !mis) begin
               case (sz)
                  2'd0: mm[k][a] = ex_di[k][7:0];
                  2'd1: begin
                     mm[k][a]        = ex_di[k][15:8];
                     mm[k][a + 8'd1] = ex_di[k][7:0];
                  end
                  default: begin
                     mm[k][a]        = ex_di[k][31:24];
                     mm[k][a + 8'd1] = ex_di[k][23:16];
                     mm[k][a + 8'd2] = ex_di[k][15:8];
                     mm[k][a + 8'd3] = ex_di[k][7:0];
                  end
               endcase
            end
            m_wb_pd[k] = res;
            m_wb_rd[k] = ex_rd[k];
            m_wb_le[k] = le;
            left[k]    = -1;
            n_commit[k]++;
         end else begin
            left[k]--;
            m_wb_le[k] = 1'b0;
         end
      end
   end

   task automatic set_in(input int k, input logic [3:0] ctrl, input logic [31:0] eo,
                         input logic [31:0] di, input logic [4:0] rd, input logic l,
                         input logic le);
      ram_ctrl[k] = ctrl;
      ex_out[k]   = eo;
      ex_di[k]    = di;
      ex_rd[k]    = rd;
      ex_l[k]     = l;
      ex_rf_le[k] = le;
   endtask

   // Present one instruction (called just after a rising edge) and hold it
   // until the model reports its commit; inputs return to a no-op afterwards.
   task automatic issue(input int k, input logic [3:0] ctrl, input logic [31:0] eo,
                        input logic [31:0] di, input logic [4:0] rd, input logic l,
                        input logic le);
      int start;
      start = n_commit[k];
      set_in(k, ctrl, eo, di, rd, l, le);
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         #1;
         if (n_commit[k] != start) break;
      end
      check($sformatf("i%0d commit within budget", k), {31'h0, n_commit[k] != start}, 32'h1);
      set_in(k, 4'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   initial begin
      logic [2:0] stall_pat;
      for (int k = 0; k < N; k++) begin
         rst[k]      = 1'b1;
         left[k]     = -1;
         n_commit[k] = 0;
         m_wb_pd[k]  = '0;
         m_wb_rd[k]  = '0;
         m_wb_le[k]  = 1'b0;
         set_in(k, 4'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) rst[k] = 1'b0;
      for (int k = 0; k < N; k++) begin
         check($sformatf("i%0d reset WB_PD", k), wb_pd[k], 32'h0);
         check($sformatf("i%0d reset WB_RF_LE", k), {31'h0, wb_rf_le[k]}, 32'h0);
      end

      // Give every RAM a defined image so loads compare against known bytes
      for (int k = 0; k < N; k++)
         for (int w = 0; w < 64; w++)
            issue(k, 4'b1110, 32'(w * 4), $urandom, 5'd0, 1'b0, 1'b0);

      // WAIT=0: word store/load, byte and halfword lanes
      issue(0, 4'b1110, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
      issue(0, 4'b1010, 32'hFFFF_FF10, 32'h0, 5'd3, 1'b1, 1'b1);
      check("w0 word load", wb_pd[0], 32'hDEAD_BEEF);
      check("w0 word load rd", {27'h0, wb_rd[0]}, 32'd3);
      check("w0 word load le", {31'h0, wb_rf_le[0]}, 32'h1);
      issue(0, 4'b1000, 32'h0000_0011, 32'h0, 5'd4, 1'b1, 1'b1);
      check("w0 byte load 0x11", wb_pd[0], 32'h0000_00AD);
      issue(0, 4'b1001, 32'h0000_0012, 32'h0, 5'd5, 1'b1, 1'b1);
      check("w0 half load 0x12", wb_pd[0], 32'h0000_BEEF);
      issue(0, 4'b1101, 32'h0000_0010, 32'hAAAA_1234, 5'd0, 1'b0, 1'b0);
      issue(0, 4'b1010, 32'h0000_0010, 32'h0, 5'd6, 1'b1, 1'b1);
      check("w0 word after half store", wb_pd[0], 32'h1234_BEEF);

      // Misaligned word load at 0x13, then a misaligned store that must not write
      set_in(0, 4'b1010, 32'h0000_0013, 32'h0, 5'd9, 1'b1, 1'b1);
      @(negedge clk);
      check("misalign pulse", {31'h0, misalign[0]}, 32'h1);
      check("misalign MEM_RF_LE", {31'h0, mem_rf_le[0]}, 32'h0);
      check("misalign PD_MEM", pd_mem[0], 32'h0);
      @(posedge clk);
      #1;
      set_in(0, 4'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0);
      check("misalign WB_RF_LE", {31'h0, wb_rf_le[0]}, 32'h0);
      @(negedge clk);
      check("misalign one cycle", {31'h0, misalign[0]}, 32'h0);
      @(posedge clk);
      #1;
      issue(0, 4'b1110, 32'h0000_0013, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
      issue(0, 4'b1010, 32'h0000_0010, 32'h0, 5'd8, 1'b1, 1'b1);
      check("ram unchanged by misaligned", wb_pd[0], 32'h1234_BEEF);

      // Non-access instruction passes EX_OUT straight through
      set_in(0, 4'h0, 32'h0000_0055, 32'h0, 5'd7, 1'b0, 1'b1);
      @(negedge clk);
      check("nonaccess PD_MEM", pd_mem[0], 32'h0000_0055);
      check("nonaccess no stall", {31'h0, mem_stall[0]}, 32'h0);
      @(posedge clk);
      #1;
      set_in(0, 4'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0);
      check("nonaccess WB_PD", wb_pd[0], 32'h0000_0055);
      check("nonaccess WB_RD", {27'h0, wb_rd[0]}, 32'd7);
      check("nonaccess WB_RF_LE", {31'h0, wb_rf_le[0]}, 32'h1);

      // WAIT=2 load: stall 1,1,0 with bubbles, WB loaded on the third edge
      issue(1, 4'b1110, 32'h0000_0040, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0);
      set_in(1, 4'b1010, 32'h0000_0040, 32'h0, 5'd4, 1'b1, 1'b1);
      stall_pat = 3'b011;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("w2 stall cycle %0d", c), {31'h0, mem_stall[1]}, {31'h0, stall_pat[c]});
         check($sformatf("w2 bubble cycle %0d", c), {31'h0, wb_rf_le[1]}, 32'h0);
         @(posedge clk);
         #1;
      end
      set_in(1, 4'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0);
      check("w2 load WB_PD", wb_pd[1], 32'hCAFE_F00D);
      check("w2 load WB_RD", {27'h0, wb_rd[1]}, 32'd4);
      check("w2 load WB_RF_LE", {31'h0, wb_rf_le[1]}, 32'h1);

      // WAIT=3 store aborted by reset in its second cycle
      issue(2, 4'b1110, 32'h0000_0020, 32'h0102_0304, 5'd0, 1'b0, 1'b0);
      set_in(2, 4'b1110, 32'h0000_0020, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst[2] = 1'b1;
      @(negedge clk);
      check("w3 stall before reset", {31'h0, mem_stall[2]}, 32'h1);
      @(posedge clk);
      #1;
      rst[2] = 1'b0;
      set_in(2, 4'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0);
      @(negedge clk);
      check("w3 idle after reset", {31'h0, mem_stall[2]}, 32'h0);
      check("w3 WB_PD cleared", wb_pd[2], 32'h0);
      @(posedge clk);
      #1;
      issue(2, 4'b1010, 32'h0000_0020, 32'h0, 5'd2, 1'b1, 1'b1);
      check("w3 aborted store left RAM", wb_pd[2], 32'h0102_0304);

      // Randomized instruction streams, checked cycle by cycle by the model
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < 80; i++) begin
            logic [3:0]  ctrl;
            logic [31:0] eo;
            logic        l;
            ctrl = {$urandom_range(0, 9) < 8, 1'($urandom), 2'($urandom_range(0, 3))};
            eo   = $urandom;
            if ($urandom_range(0, 9) < 7) eo[1:0] = 2'b00;
            l    = ctrl[3] && (ctrl[1:0] != 2'b11) && !ctrl[2];
            issue(k, ctrl, eo, $urandom, 5'($urandom), l, 1'($urandom));
         end
      end

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
